// File: rtl/snn_layer_serial.sv
// Time-multiplexed binary-weight LIF layer: one shared datapath walks the neurons
// one per cycle, membranes in a register file, byte-wide config port.
module snn_layer_serial #(
  parameter int INPUTS         = 16,
  parameter int NEURONS        = 16,
  parameter int POTENTIAL_BITS = 8,
  parameter int THRESHOLD_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  input  logic [1:0]          cfg_sel,
  input  logic [7:0]          cfg_data,
  output logic                cfg_ready,
  input  logic                start,
  input  logic [INPUTS-1:0]   in_spikes,
  output logic                busy,
  output logic                out_valid,
  output logic [NEURONS-1:0]  out_spikes
);
  localparam int W  = INPUTS * NEURONS;
  localparam int P  = POTENTIAL_BITS;
  localparam int T  = THRESHOLD_BITS;
  localparam int IW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int SW = $clog2(INPUTS + 1) + 1;
  localparam int VW = ((P > SW) ? P : SW) + 2;

  typedef logic signed [VW-1:0] v_t;
  typedef logic signed [P-1:0]  p_t;
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  localparam v_t VMAX = v_t'((1 << (P - 1)) - 1);
  localparam v_t VMIN = v_t'(-(1 << (P - 1)));
  localparam p_t PMAX = p_t'((1 << (P - 1)) - 1);
  localparam p_t PMIN = p_t'(-(1 << (P - 1)));

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [INPUTS-1:0]  x_q, x_d;
  logic [W-1:0]       weights_q, weights_d;
  logic [T-1:0]       thr_q, thr_d;
  logic [2:0]         shift_q, shift_d;
  p_t                 mem_q [NEURONS];
  p_t                 mem_d [NEURONS];
  logic [NEURONS-1:0] spk_q, spk_d;
  logic [NEURONS-1:0] out_spikes_q, out_spikes_d;

  // Shared neuron datapath for the neuron selected by idx_q
  logic [INPUTS-1:0] w_n;
  v_t                sum, u_ext, leak, v;
  p_t                v_sat, thr_p, u_new;
  logic              spike;

  always_comb begin
    w_n   = weights_q[idx_q*INPUTS +: INPUTS];
    sum   = '0;
    for (int i = 0; i < INPUTS; i++)
      if (x_q[i]) sum = w_n[i] ? sum + v_t'(1) : sum - v_t'(1);
    u_ext = v_t'(mem_q[idx_q]);
    leak  = u_ext >>> shift_q;
    v     = (shift_q == 3'd0) ? u_ext + sum : u_ext - leak + sum;
    v_sat = (v > VMAX) ? PMAX : (v < VMIN) ? PMIN : v[P-1:0];
    thr_p = $signed({{(P-T){1'b0}}, thr_q});
    spike = (v_sat >= thr_p);
    u_new = spike ? v_sat - thr_p : v_sat;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    x_d          = x_q;
    weights_d    = weights_q;
    thr_d        = thr_q;
    shift_d      = shift_q;
    mem_d        = mem_q;
    spk_d        = spk_q;
    out_spikes_d = out_spikes_q;
    busy         = (state_q == S_EVAL);
    cfg_ready    = !busy;
    out_valid    = (state_q == S_DONE);

    // Config lands on the same edge a start is taken, so that timestep sees it
    if (cfg_valid && cfg_ready) begin
      case (cfg_sel)
        2'b00: weights_d = {cfg_data, weights_q[W-1:8]};
        2'b01: thr_d     = cfg_data[T-1:0];
        2'b10: shift_d   = cfg_data[2:0];
        default: for (int n = 0; n < NEURONS; n++) mem_d[n] = '0;
      endcase
    end

    case (state_q)
      S_EVAL: begin
        mem_d[idx_q] = u_new;
        spk_d[idx_q] = spike;
        if (idx_q == IW'(NEURONS - 1)) begin
          state_d      = S_DONE;
          idx_d        = '0;
          out_spikes_d = spk_d;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        if (start) begin
          state_d = S_EVAL;
          x_d     = in_spikes;
          idx_d   = '0;
          spk_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      x_q          <= '0;
      weights_q    <= '1;
      thr_q        <= T'(3);
      shift_q      <= '0;
      spk_q        <= '0;
      out_spikes_q <= '0;
      for (int n = 0; n < NEURONS; n++) mem_q[n] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      x_q          <= x_d;
      weights_q    <= weights_d;
      thr_q        <= thr_d;
      shift_q      <= shift_d;
      spk_q        <= spk_d;
      out_spikes_q <= out_spikes_d;
      for (int n = 0; n < NEURONS; n++) mem_q[n] <= mem_d[n];
    end
  end

  assign out_spikes = out_spikes_q;
endmodule
